// File: rtl/systolic_array.sv
// 2x2 weight-stationary systolic array, signed Q8.8. Activations flow right,
// partial sums flow down, and each column's bottom PE produces one element of A*W.

module systolic_mult (
  input  logic [15:0] a,
  input  logic [15:0] w,
  output logic [15:0] out
);

  logic signed [31:0] a_ext_s;
  logic signed [31:0] w_ext_s;
  logic signed [31:0] prod_s;
  logic               unused_prod_bits_s;

  // Q8.8 x Q8.8 product, rescaled back to Q8.8 by dropping the low 8 fraction bits
  always_comb begin
    a_ext_s            = {{16{a[15]}}, a};
    w_ext_s            = {{16{w[15]}}, w};
    prod_s             = a_ext_s * w_ext_s;
    out                = prod_s[23:8];
    unused_prod_bits_s = ^{prod_s[31:24], prod_s[7:0]};
  end

endmodule

module systolic_pe (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] input_in,
  input  logic        valid_in,
  input  logic [15:0] psum_in,
  input  logic [15:0] weight_in,
  input  logic        accept_w,
  input  logic        switch_in,
  output logic [15:0] input_out,
  output logic        valid_out,
  output logic [15:0] weight_out,
  output logic        switch_out,
  output logic [15:0] pe_psum_out,
  output logic        pe_valid_out
);

  logic [15:0] input_q, input_d;
  logic        valid_q, valid_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] active_q, active_d;
  logic        switch_q, switch_d;
  logic [15:0] psum_q, psum_d;
  logic        pvalid_q, pvalid_d;
  logic [15:0] prod_s;

  systolic_mult mult (
    .a   (input_q),
    .w   (active_q),
    .out (prod_s)
  );

  // Next-state for both pipeline stages and the weight shadow/active pair
  always_comb begin
    input_d  = input_q;
    valid_d  = valid_in;
    switch_d = switch_in;
    shadow_d = shadow_q;
    active_d = active_q;
    psum_d   = 16'h0000;
    pvalid_d = valid_q;
    if (valid_in) begin
      input_d = input_in;
    end else begin
      input_d = input_q;
    end
    if (accept_w) begin
      shadow_d = weight_in;
    end else begin
      shadow_d = shadow_q;
    end
    // Switching takes the shadow's next value so a same-edge shift is not lost
    if (switch_in) begin
      active_d = shadow_d;
    end else begin
      active_d = active_q;
    end
    if (valid_q) begin
      psum_d = prod_s + psum_in;
    end else begin
      psum_d = 16'h0000;
    end
  end

  // PE state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      input_q  <= 16'h0000;
      valid_q  <= 1'b0;
      shadow_q <= 16'h0000;
      active_q <= 16'h0000;
      switch_q <= 1'b0;
      psum_q   <= 16'h0000;
      pvalid_q <= 1'b0;
    end else begin
      input_q  <= input_d;
      valid_q  <= valid_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      switch_q <= switch_d;
      psum_q   <= psum_d;
      pvalid_q <= pvalid_d;
    end
  end

  assign input_out    = input_q;
  assign valid_out    = valid_q;
  assign weight_out   = shadow_q;
  assign switch_out   = switch_q;
  assign pe_psum_out  = psum_q;
  assign pe_valid_out = pvalid_q;

endmodule

module systolic_array (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ub_rd_col_size_in,
  input  logic        ub_rd_col_size_valid_in,
  input  logic [15:0] sys_data_in_1x,
  input  logic [15:0] sys_data_in_2x,
  input  logic        sys_start,
  input  logic [15:0] sys_weight_in_x1,
  input  logic [15:0] sys_weight_in_x2,
  input  logic        sys_accept_w_1,
  input  logic        sys_accept_w_2,
  input  logic        sys_switch_in,
  output logic [15:0] sys_data_out_x1,
  output logic [15:0] sys_data_out_x2,
  output logic        sys_valid_out_x1,
  output logic        sys_valid_out_x2
);

  logic [15:0] col_size_q, col_size_d;
  logic        col1_en_s, col2_en_s;
  logic        pe11_vin_s, pe12_vin_s, pe21_vin_s, pe22_vin_s;

  logic [15:0] pe11_in_s, pe21_in_s;
  logic        pe11_valid_s, pe21_valid_s;
  logic [15:0] pe11_w_s, pe12_w_s;
  logic        pe11_sw_s, pe12_sw_s;
  logic [15:0] pe11_psum_s, pe12_psum_s;
  logic        unused_pe11_pv_s, unused_pe12_pv_s;
  logic [15:0] unused_pe12_in_s, unused_pe22_in_s;
  logic        unused_pe12_v_s, unused_pe22_v_s;
  logic [15:0] unused_pe21_w_s, unused_pe22_w_s;
  logic        unused_pe21_sw_s, unused_pe22_sw_s;

  // Column-size register and the per-column valid gating it controls
  always_comb begin
    if (ub_rd_col_size_valid_in) begin
      col_size_d = ub_rd_col_size_in;
    end else begin
      col_size_d = col_size_q;
    end
    col1_en_s  = (col_size_q >= 16'd1);
    col2_en_s  = (col_size_q >= 16'd2);
    pe11_vin_s = sys_start & col1_en_s;
    pe21_vin_s = pe11_valid_s & col1_en_s;
    pe12_vin_s = pe11_valid_s & col2_en_s;
    pe22_vin_s = pe21_valid_s & col2_en_s;
  end

  // Column-size storage
  always_ff @(posedge clk) begin
    if (rst) begin
      col_size_q <= 16'h0000;
    end else begin
      col_size_q <= col_size_d;
    end
  end

  systolic_pe pe11 (
    .clk(clk), .rst(rst),
    .input_in(sys_data_in_1x), .valid_in(pe11_vin_s), .psum_in(16'h0000),
    .weight_in(sys_weight_in_x1), .accept_w(sys_accept_w_1), .switch_in(sys_switch_in),
    .input_out(pe11_in_s), .valid_out(pe11_valid_s), .weight_out(pe11_w_s),
    .switch_out(pe11_sw_s), .pe_psum_out(pe11_psum_s), .pe_valid_out(unused_pe11_pv_s)
  );

  systolic_pe pe12 (
    .clk(clk), .rst(rst),
    .input_in(pe11_in_s), .valid_in(pe12_vin_s), .psum_in(16'h0000),
    .weight_in(sys_weight_in_x2), .accept_w(sys_accept_w_2), .switch_in(pe11_sw_s),
    .input_out(unused_pe12_in_s), .valid_out(unused_pe12_v_s), .weight_out(pe12_w_s),
    .switch_out(pe12_sw_s), .pe_psum_out(pe12_psum_s), .pe_valid_out(unused_pe12_pv_s)
  );

  // Row 2 samples one edge after row 1, matching the psum arriving from above
  systolic_pe pe21 (
    .clk(clk), .rst(rst),
    .input_in(sys_data_in_2x), .valid_in(pe21_vin_s), .psum_in(pe11_psum_s),
    .weight_in(pe11_w_s), .accept_w(sys_accept_w_1), .switch_in(pe11_sw_s),
    .input_out(pe21_in_s), .valid_out(pe21_valid_s), .weight_out(unused_pe21_w_s),
    .switch_out(unused_pe21_sw_s), .pe_psum_out(sys_data_out_x1), .pe_valid_out(sys_valid_out_x1)
  );

  systolic_pe pe22 (
    .clk(clk), .rst(rst),
    .input_in(pe21_in_s), .valid_in(pe22_vin_s), .psum_in(pe12_psum_s),
    .weight_in(pe12_w_s), .accept_w(sys_accept_w_2), .switch_in(pe12_sw_s),
    .input_out(unused_pe22_in_s), .valid_out(unused_pe22_v_s), .weight_out(unused_pe22_w_s),
    .switch_out(unused_pe22_sw_s), .pe_psum_out(sys_data_out_x2), .pe_valid_out(sys_valid_out_x2)
  );

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: expected column results are queued when the
// activations are driven and compared as each column reports a valid result.

module tb_systolic_array;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ub_rd_col_size_in;
  logic        ub_rd_col_size_valid_in;
  logic [15:0] sys_data_in_1x, sys_data_in_2x;
  logic        sys_start;
  logic [15:0] sys_weight_in_x1, sys_weight_in_x2;
  logic        sys_accept_w_1, sys_accept_w_2;
  logic        sys_switch_in;
  logic [15:0] sys_data_out_x1, sys_data_out_x2;
  logic        sys_valid_out_x1, sys_valid_out_x2;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [15:0] q1[$];
  logic [15:0] q2[$];

  always #5 clk = ~clk;

  systolic_array dut (
    .clk(clk), .rst(rst),
    .ub_rd_col_size_in(ub_rd_col_size_in), .ub_rd_col_size_valid_in(ub_rd_col_size_valid_in),
    .sys_data_in_1x(sys_data_in_1x), .sys_data_in_2x(sys_data_in_2x), .sys_start(sys_start),
    .sys_weight_in_x1(sys_weight_in_x1), .sys_weight_in_x2(sys_weight_in_x2),
    .sys_accept_w_1(sys_accept_w_1), .sys_accept_w_2(sys_accept_w_2),
    .sys_switch_in(sys_switch_in),
    .sys_data_out_x1(sys_data_out_x1), .sys_data_out_x2(sys_data_out_x2),
    .sys_valid_out_x1(sys_valid_out_x1), .sys_valid_out_x2(sys_valid_out_x2)
  );

  // Reference Q8.8 multiply: full signed product, drop 8 fraction bits, keep 16 bits
  function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] w);
    logic signed [15:0] as;
    logic signed [15:0] ws;
    logic signed [31:0] p;
    as = a;
    ws = w;
    p  = 32'(as) * 32'(ws);
    p  = p >>> 8;
    return p[15:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock; outputs sampled 1 time unit after the edge and scored
  task automatic step();
    @(posedge clk);
    #1;
    if (sys_valid_out_x1) begin
      if (q1.size() == 0) chk("x1_unexpected_valid", {15'd0, sys_valid_out_x1}, 16'h0000);
      else chk("x1_result", sys_data_out_x1, q1.pop_front());
    end else begin
      chk("x1_idle_data", sys_data_out_x1, 16'h0000);
    end
    if (sys_valid_out_x2) begin
      if (q2.size() == 0) chk("x2_unexpected_valid", {15'd0, sys_valid_out_x2}, 16'h0000);
      else chk("x2_result", sys_data_out_x2, q2.pop_front());
    end else begin
      chk("x2_idle_data", sys_data_out_x2, 16'h0000);
    end
  endtask

  task automatic clear_inputs();
    ub_rd_col_size_in       = 16'h0000;
    ub_rd_col_size_valid_in = 1'b0;
    sys_data_in_1x          = 16'h0000;
    sys_data_in_2x          = 16'h0000;
    sys_start               = 1'b0;
    sys_weight_in_x1        = 16'h0000;
    sys_weight_in_x2        = 16'h0000;
    sys_accept_w_1          = 1'b0;
    sys_accept_w_2          = 1'b0;
    sys_switch_in           = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    q1.delete();
    q2.delete();
    step();
    rst = 1'b0;
  endtask

  task automatic set_cols(input logic [15:0] n);
    ub_rd_col_size_in       = n;
    ub_rd_col_size_valid_in = 1'b1;
    step();
    ub_rd_col_size_valid_in = 1'b0;
    ub_rd_col_size_in       = 16'h0000;
  endtask

  // Shared weight-load + stream sequence; A = [[1,2],[5,6]], W = [[1,4.34765625],[5.75,1]]
  task automatic run_seq(input logic sw_en, input logic internal, input logic abort, input logic c2);
    logic [15:0] w11, w21, w12, w22;
    w11 = sw_en ? 16'h0100 : 16'h0000;
    w21 = sw_en ? 16'h05C0 : 16'h0000;
    w12 = sw_en ? 16'h0459 : 16'h0000;
    w22 = sw_en ? 16'h0100 : 16'h0000;
    // E1
    sys_weight_in_x1 = 16'h05C0; sys_accept_w_1 = 1'b1;
    step();
    // E2
    sys_weight_in_x1 = 16'h0100; sys_weight_in_x2 = 16'h0100; sys_accept_w_2 = 1'b1;
    sys_switch_in = sw_en; sys_start = 1'b1; sys_data_in_1x = 16'h0100;
    q1.push_back(qmul(16'h0100, w11) + qmul(16'h0200, w21));
    q1.push_back(qmul(16'h0500, w11) + qmul(16'h0600, w21));
    if (c2) begin
      q2.push_back(qmul(16'h0100, w12) + qmul(16'h0200, w22));
      q2.push_back(qmul(16'h0500, w12) + qmul(16'h0600, w22));
    end
    step();
    // E3
    sys_accept_w_1 = 1'b0; sys_weight_in_x1 = 16'h0000; sys_weight_in_x2 = 16'h0459;
    sys_data_in_1x = 16'h0500; sys_data_in_2x = 16'h0200;
    step();
    if (internal) chk("pe11_psum_e3", dut.pe11.pe_psum_out, 16'h0100);
    if (abort) begin
      clear_inputs();
      rst = 1'b1;
      q1.delete();
      q2.delete();
      step();
      rst = 1'b0;
      chk("abort_v1", {15'd0, sys_valid_out_x1}, 16'h0000);
      chk("abort_v2", {15'd0, sys_valid_out_x2}, 16'h0000);
      chk("abort_d1", sys_data_out_x1, 16'h0000);
      chk("abort_d2", sys_data_out_x2, 16'h0000);
      return;
    end
    // E4
    sys_accept_w_2 = 1'b0; sys_weight_in_x2 = 16'h0000; sys_switch_in = 1'b0;
    sys_start = 1'b0; sys_data_in_1x = 16'h0000; sys_data_in_2x = 16'h0600;
    step();
    if (internal) begin
      chk("pe12_psum_e4", dut.pe12.pe_psum_out, 16'h0459);
      chk("x1_e4", sys_data_out_x1, 16'h0C80);
      chk("x1_valid_e4", {15'd0, sys_valid_out_x1}, 16'h0001);
    end
    // E5
    sys_data_in_2x = 16'h0000;
    step();
    if (internal) begin
      chk("x1_e5", sys_data_out_x1, 16'h2780);
      chk("pe21_mult_e5", dut.pe21.mult.out, 16'h2280);
      chk("x2_e5", sys_data_out_x2, 16'h0659);
    end
    if (!c2) chk("x2_disabled_valid", {15'd0, sys_valid_out_x2}, 16'h0000);
    // E6
    step();
    if (internal) begin
      chk("x2_e6", sys_data_out_x2, 16'h1BBD);
      chk("pe22_mult_e6", dut.pe22.mult.out, 16'h0600);
    end
    // E7 onward: stream drained
    step();
    chk("v1_e7", {15'd0, sys_valid_out_x1}, 16'h0000);
    chk("v2_e7", {15'd0, sys_valid_out_x2}, 16'h0000);
    step();
    chk("q1_drained", 16'(q1.size()), 16'h0000);
    chk("q2_drained", 16'(q2.size()), 16'h0000);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_v1", {15'd0, sys_valid_out_x1}, 16'h0000);
    chk("rst_v2", {15'd0, sys_valid_out_x2}, 16'h0000);
    chk("rst_col_size", dut.col_size_q, 16'h0000);

    // Full two-column run with switch and internal probes
    set_cols(16'd2);
    run_seq(1'b1, 1'b1, 1'b0, 1'b1);

    // Column 2 disabled
    do_reset();
    set_cols(16'd1);
    run_seq(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream, then stream after shadow-only load: active weights remain 0
    do_reset();
    set_cols(16'd2);
    run_seq(1'b1, 1'b0, 1'b1, 1'b1);
    set_cols(16'd2);
    run_seq(1'b0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/systolic_array.md
# systolic_array

2×2 weight-stationary systolic array for the TPU datapath, in signed Q8.8 fixed point. Activation rows enter from the left and move right. Weights are preloaded per column from the top into shadow registers and switched into active registers. Partial sums flow down, so each column's bottom output is one element of A·W.

## Interface
- No parameters; array size fixed at 2×2, data width 16 (Q8.8).
- clk  in  1  clock. rst  in  1  reset, synchronous, active-high.
- ub_rd_col_size_in  in  16  number of enabled columns.
- ub_rd_col_size_valid_in  in  1  latch ub_rd_col_size_in this edge.
- sys_data_in_1x  in  16  row-1 activation. sys_data_in_2x  in  16  row-2 activation.
- sys_start  in  1  row-1 activation valid.
- sys_weight_in_x1 / sys_weight_in_x2  in  16  weight for column 1 / column 2.
- sys_accept_w_1 / sys_accept_w_2  in  1  shift weight into column 1 / column 2.
- sys_switch_in  in  1  copy shadow weights to active, wavefront.
- sys_data_out_x1 / sys_data_out_x2  out  16  column 1 / column 2 result (bottom psum).
- sys_valid_out_x1 / sys_valid_out_x2  out  1  result valid.

## Operation
- PE instances are pe11, pe12, pe21, pe22 (row, col). Each exposes the registered pe_psum_out and a multiplier submodule mult with combinational output out.
- **Fixed-point arithmetic:** product = signed 32-bit a·w; arithmetic shift right 8; truncate to 16 bits. Add psum_in with 16-bit wraparound; no saturation.
- **Weight load:** column c shifts on an edge where sys_accept_w_c=1.
  - pe1c.shadow ← sys_weight_in_xc and pe2c.shadow ← old pe1c.shadow, same edge.
  - Feed each column bottom-row weight first.
- **Switch:** on an edge where a PE's switch_in=1, active ← the value its shadow takes at that same edge. This bypass covers a simultaneous shift.
  - pe11.switch_in = sys_switch_in.
  - pe12 and pe21 take pe11.switch_reg.
  - pe22 takes pe12.switch_reg.
  - switch_reg ← switch_in every edge.
- **PE stage 1:**
  - valid_reg ← valid_in, every edge.
  - If valid_in: input_reg ← input_in.
- **PE stage 2:**
  - psum_out ← valid_reg ? input_reg·active + psum_in : 0.
  - pvalid ← valid_reg.
- **Connections:**
  - pe11 takes input sys_data_in_1x and valid sys_start.
  - pe12 takes pe11.input_reg and pe11.valid_reg.
  - pe21 takes input sys_data_in_2x and valid pe11.valid_reg, giving a one-cycle row skew.
  - pe22 takes pe21.input_reg and pe21.valid_reg.
  - Row-1 psum_in = 0. pe21.psum_in = pe11.psum_out; pe22.psum_in = pe12.psum_out.
- **Outputs:** sys_data_out_x1 = pe21.psum_out, sys_valid_out_x1 = pe21.pvalid; x2 same from pe22.
- **Column enable:**
  - col_size register (16 bits) loads on ub_rd_col_size_valid_in and otherwise holds.
  - Column c is enabled iff c ≤ col_size.
  - A disabled column forces its PEs' valid_in to 0, so its outputs and valid stay 0.

## Timing
- Reset: all registers clear to 0, including shadow, active, input_reg, psum, valids, switch regs and col_size. All outputs are 0 the cycle after reset, and rst mid-operation aborts everything.
- Latency, activation to output: an activation sampled at edge k gives pe11.psum at k+1, pe12.psum at k+2 and sys_data_out_x1 at k+2; sys_data_out_x2 appears at k+3 (row-2 data is sampled one edge after row 1).
- A continuous 2-row stream yields two back-to-back valid results per column.
- Weights take effect only after a switch. An active weight is unaffected by later shadow loads until the next switch.
- Holding switch for multiple cycles is harmless.

## Test plan
Shared setup for tests 1–4:
- Reset, col_size=2.
- Let E1 be the edge on which sys_accept_w_1 first samples 1.
- E1: col1 weight 5.75. E2: col1 weight 1.0, col2 weight 1.0.
- E3: col2 weight 4.34765625.
- E2–E3: sys_start=1, sys_switch_in=1; sys_data_in_1x = 1.0, then 5.0.
- E3–E4: sys_data_in_2x = 2.0, then 6.0.

Tests:
1. After E3: pe11.pe_psum_out=0x0100 (1.0). After E4: pe12.pe_psum_out=0x0459.
2. After E4: sys_data_out_x1=0x0C80 (12.5), valid. After E5: 0x2780 (39.5); pe21.mult.out=0x2280 (34.5).
3. After E5: sys_data_out_x2=0x0659. After E6: 0x1BBD (27.73828125); pe22.mult.out=0x0600.
4. E7 onward: both valids 0 and data 0.
5. col_size=1, rerun: column 2 outputs and valid stay 0; column 1 unchanged.
6. Assert rst mid-stream: the next cycle all outputs are 0, and after reset a stream with no new switch computes with weight 0, giving 0 outputs.
